// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and full-adder BIST constants
package bist_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;
  localparam logic [3:0] GOLDEN_SIG_FA   = 4'b1101;
  localparam int         NUM_PATTERNS_FA = 7;
endpackage

// File: rtl/bist_sat_counter.sv
// bist_sat_counter: increment-only counter that sticks at all-ones
module bist_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/bist_session_sequencer.sv
// bist_session_sequencer: runs one clear/pattern/settle BIST session and grades the MISR signature
module bist_session_sequencer
  import bist_pkg::*;
#(
  parameter int               SIG_W         = 4,
  parameter int               NUM_PATTERNS  = NUM_PATTERNS_FA,
  parameter int               SETTLE_CYCLES = 1,
  parameter logic [SIG_W-1:0] GOLDEN        = GOLDEN_SIG_FA,
  parameter int               CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] signature_in,
  output logic             testmode,
  output logic             bist_clear,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] last_signature,
  output logic [CNT_W-1:0] fail_count
);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PATTERNS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  state_t st, nxt;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic sample;
  always_comb begin
    nxt = st;
    sample = 1'b0;
    case (st)
      IDLE:   nxt = (start && !abort) ? CLEAR : IDLE;
      CLEAR:  nxt = abort ? IDLE : RUN;
      RUN:    nxt = abort ? IDLE : (pcnt == P_LAST) ? SETTLE : RUN;
      SETTLE: begin
        sample = !abort && (scnt == S_LAST);
        nxt = abort ? IDLE : sample ? DONE : SETTLE;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st <= IDLE;
      pcnt <= '0;
      scnt <= '0;
      testmode <= 1'b0;
      bist_clear <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      last_signature <= '0;
    end else begin
      st <= nxt;
      pcnt <= (st == RUN) ? pcnt + 1'b1 : '0;
      scnt <= (st == SETTLE) ? scnt + 1'b1 : '0;
      testmode <= (nxt == CLEAR) || (nxt == RUN) || (nxt == SETTLE);
      bist_clear <= nxt == CLEAR;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      if (sample) begin
        last_signature <= signature_in;
        pass <= signature_in == GOLDEN;
      end
    end
  bist_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (sample && (signature_in != GOLDEN)),
    .count(fail_count)
  );
endmodule

// File: tb/tb_bist_session_sequencer.sv
// tb_bist_session_sequencer: directed checks of session timing, grading, abort, reset and saturation
module tb_bist_session_sequencer;
  logic clock, reset, start, abort;
  logic [3:0] sig;
  logic testmode, bist_clear, busy, done, pass;
  logic [3:0] last_signature;
  logic [7:0] fail_count;
  logic tm2, clr2, busy2, done2, pass2;
  logic [3:0] last2;
  logic [1:0] fc2;
  int errors = 0;
  int checks = 0;

  bist_session_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .signature_in(sig),
    .testmode(testmode), .bist_clear(bist_clear), .busy(busy), .done(done), .pass(pass),
    .last_signature(last_signature), .fail_count(fail_count)
  );

  bist_session_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .signature_in(sig),
    .testmode(tm2), .bist_clear(clr2), .busy(busy2), .done(done2), .pass(pass2),
    .last_signature(last2), .fail_count(fc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drives one session from a single start pulse and records what it observed per edge offset
  task automatic run_session(input logic [3:0] s, output int tm, output int dn_at, output int dn_n,
                             output int clr_at, output int clr_n);
    tm = 0; dn_at = -1; dn_n = 0; clr_at = -1; clr_n = 0;
    sig = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) tick();
      tm += int'(testmode);
      if (done) begin dn_n++; if (dn_at < 0) dn_at = j; end
      if (bist_clear) begin clr_n++; if (clr_at < 0) clr_at = j; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; sig = 4'h0;
    #2 reset = 1'b0;
    #10;
    checks++; if ({testmode, bist_clear, busy, done, pass} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {testmode, bist_clear, busy, done, pass}); end
    checks++; if (last_signature !== 4'h0) begin errors++; $display("FAIL reset_last_sig: got %h want 0", last_signature); end
    checks++; if (fail_count !== 8'h0) begin errors++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
    checks++; if ({tm2, clr2, busy2, done2, pass2, last2, fc2} !== 11'b0) begin errors++; $display("FAIL reset_dut2: got %b want 0", {tm2, clr2, busy2, done2, pass2, last2, fc2}); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_pass();
    int tm, dn_at, dn_n, clr_at, clr_n;
    run_session(4'b1101, tm, dn_at, dn_n, clr_at, clr_n);
    checks++; if (clr_at !== 0 || clr_n !== 1) begin errors++; $display("FAIL pass_bist_clear: got at=%0d n=%0d want at=0 n=1", clr_at, clr_n); end
    checks++; if (tm !== 9) begin errors++; $display("FAIL pass_testmode_cycles: got %0d want 9", tm); end
    checks++; if (dn_at !== 9 || dn_n !== 1) begin errors++; $display("FAIL pass_done: got at=%0d n=%0d want at=9 n=1", dn_at, dn_n); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_result: got %b want 1", pass); end
    checks++; if (last_signature !== 4'b1101) begin errors++; $display("FAIL pass_last_sig: got %b want 1101", last_signature); end
    checks++; if (fail_count !== 8'd0) begin errors++; $display("FAIL pass_fail_count: got %0d want 0", fail_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_fail();
    int tm, dn_at, dn_n, clr_at, clr_n;
    run_session(4'b1001, tm, dn_at, dn_n, clr_at, clr_n);
    checks++; if (dn_at !== 9 || dn_n !== 1) begin errors++; $display("FAIL fail_done: got at=%0d n=%0d want at=9 n=1", dn_at, dn_n); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fail_result: got %b want 0", pass); end
    checks++; if (last_signature !== 4'b1001) begin errors++; $display("FAIL fail_last_sig: got %b want 1001", last_signature); end
    checks++; if (fail_count !== 8'd1) begin errors++; $display("FAIL fail_count: got %0d want 1", fail_count); end
    checks++; if (fc2 !== 2'd1) begin errors++; $display("FAIL fail_count_w2: got %0d want 1", fc2); end
  endtask

  task automatic test_abort();
    int dn_n = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, testmode, bist_clear} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {busy, testmode, bist_clear}); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_stay: got %b want 0", busy); end
    sig = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if ({busy, testmode} !== 2'b11) begin errors++; $display("FAIL abort_pre_run: got %b want 11", {busy, testmode}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, testmode} !== 2'b00) begin errors++; $display("FAIL abort_run_exit: got %b want 00", {busy, testmode}); end
    for (int j = 0; j < 12; j++) begin
      tick();
      dn_n += int'(done);
    end
    checks++; if (dn_n !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dn_n); end
    checks++; if (pass !== 1'b0 || last_signature !== 4'b1001) begin errors++; $display("FAIL abort_result_held: got pass=%b sig=%b want pass=0 sig=1001", pass, last_signature); end
    checks++; if (fail_count !== 8'd1) begin errors++; $display("FAIL abort_fail_count: got %0d want 1", fail_count); end
  endtask

  task automatic test_async_reset();
    sig = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    checks++; if ({busy, testmode} !== 2'b11) begin errors++; $display("FAIL areset_pre: got %b want 11", {busy, testmode}); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({testmode, bist_clear, busy, done, pass} !== 5'b0) begin errors++; $display("FAIL areset_flags: got %b want 00000", {testmode, bist_clear, busy, done, pass}); end
    checks++; if (last_signature !== 4'h0 || fail_count !== 8'h0) begin errors++; $display("FAIL areset_state: got sig=%h cnt=%0d want sig=0 cnt=0", last_signature, fail_count); end
    #2 reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_no_resume: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n = 0, c = 0;
    int exp_fc[5] = '{1, 2, 3, 3, 3};
    sig = 4'b1001;
    start = 1'b1;
    tick();
    for (int j = 0; j < 55; j++) begin
      if (j > 0) tick();
      if (done) begin
        if (n < 5) begin
          checks++; if (j !== 9 + 11 * n) begin errors++; $display("FAIL b2b_done_edge: got %0d want %0d", j, 9 + 11 * n); end
          checks++; if (fc2 !== exp_fc[n][1:0]) begin errors++; $display("FAIL b2b_sat_count: got %0d want %0d", fc2, exp_fc[n]); end
        end
        n++;
      end
      if (bist_clear) begin
        checks++; if (j !== 11 * c) begin errors++; $display("FAIL b2b_clear_edge: got %0d want %0d", j, 11 * c); end
        c++;
      end
    end
    start = 1'b0;
    checks++; if (n !== 5 || c !== 5) begin errors++; $display("FAIL b2b_sessions: got done=%0d clear=%0d want 5 5", n, c); end
    checks++; if (fail_count !== 8'd5) begin errors++; $display("FAIL b2b_wide_count: got %0d want 5", fail_count); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_ignore_start();
    int tm = 0, dn_at = -1, dn_n = 0, clr_n = 0;
    sig = 4'b1101;
    start = 1'b1;
    tick();
    for (int j = 0; j < 15; j++) begin
      if (j > 0) tick();
      start = (j == 3 || j == 4 || j == 9);
      tm += int'(testmode);
      clr_n += int'(bist_clear);
      if (done) begin dn_n++; if (dn_at < 0) dn_at = j; end
    end
    start = 1'b0;
    checks++; if (dn_n !== 1 || dn_at !== 9) begin errors++; $display("FAIL ignore_done: got at=%0d n=%0d want at=9 n=1", dn_at, dn_n); end
    checks++; if (clr_n !== 1) begin errors++; $display("FAIL ignore_clears: got %0d want 1", clr_n); end
    checks++; if (tm !== 9) begin errors++; $display("FAIL ignore_testmode: got %0d want 9", tm); end
    checks++; if (pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_end: got pass=%b busy=%b want 1 0", pass, busy); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_ignore_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
